// File: rtl/sva_seq_pkg.sv
// Shared types and the per-tick evaluation function for the sva_seq_checker.
// Stage data is carried at fixed maximum widths (16 stages, 32-bit stamps) so one function serves every parameterisation.
package sva_seq_pkg;

  localparam int MAX_DEPTH = 16;
  localparam int MAX_TS    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } ctrl_fsm_t;

  typedef logic [MAX_TS-1:0]                  ts_t;
  typedef logic [MAX_DEPTH-1:0][MAX_TS-1:0]   ts_vec_t;

  typedef struct packed {
    logic [MAX_DEPTH-1:0] act;
    ts_vec_t              ts;
    logic                 succ;
    ts_t                  succ_ts;
    logic [4:0]           nfail;
    logic [3:0]           fail_stage;
    ts_t                  fail_ts;
  } eval_t;

  // Failures are scanned low to high so the highest failing stage wins the report.
  function automatic eval_t seq_eval(input int                   depth,
                                     input logic                 imply,
                                     input logic [MAX_DEPTH-1:0] act,
                                     input ts_vec_t              ts,
                                     input logic [MAX_DEPTH-1:0] s,
                                     input ts_t                  t);
    eval_t r;
    r = '0;
    if (s[0]) begin
      if (depth == 1) begin
        r.succ    = 1'b1;
        r.succ_ts = t;
      end else begin
        r.act[1] = 1'b1;
        r.ts[1]  = t;
      end
    end else if (!imply) begin
      r.nfail   = 5'd1;
      r.fail_ts = t;
    end
    for (int k = 1; k < MAX_DEPTH; k++) begin
      if (k < depth && act[k]) begin
        if (!s[k]) begin
          r.nfail      = r.nfail + 5'd1;
          r.fail_stage = 4'(k);
          r.fail_ts    = ts[k];
        end else if (k == depth - 1) begin
          r.succ    = 1'b1;
          r.succ_ts = ts[k];
        end
      end
    end
    for (int k = 2; k < MAX_DEPTH; k++) begin
      if (k < depth && act[k-1] && s[k-1]) begin
        r.act[k] = 1'b1;
        r.ts[k]  = ts[k-1];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sva_seq_checker_if.sv
// Bus between the sequence checker and its environment: user clock and step
// expressions in, success/failure reports and counters out.
interface sva_seq_checker_if #(
  parameter int DEPTH     = 2,
  parameter int TS_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
);
  localparam int FS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                 gclk;
  logic [DEPTH-1:0]     ev;
  logic                 busy;
  logic                 succ;
  logic [TS_WIDTH-1:0]  succ_ts;
  logic                 fail;
  logic [FS_W-1:0]      fail_stage;
  logic [TS_WIDTH-1:0]  fail_ts;
  logic                 fail_multi;
  logic [CNT_WIDTH-1:0] succ_cnt;
  logic [CNT_WIDTH-1:0] fail_cnt;

  modport master (
    output gclk, ev,
    input  busy, succ, succ_ts, fail, fail_stage, fail_ts, fail_multi, succ_cnt, fail_cnt
  );

  modport slave (
    input  gclk, ev,
    output busy, succ, succ_ts, fail, fail_stage, fail_ts, fail_multi, succ_cnt, fail_cnt
  );
endinterface

// File: rtl/sva_gclk_edge.sv
// Two-flop rising-edge detector that treats the user clock as plain data.
// grst holds the detector cleared so no stale edge survives a user reset.
module sva_gclk_edge (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_grst,
  input  logic i_gclk,
  output logic o_tick
);
  logic r_gclk_d0;
  logic r_gclk_d1;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gclk_d0 <= 1'b0;
      r_gclk_d1 <= 1'b0;
    end else if (i_grst) begin
      r_gclk_d0 <= 1'b0;
      r_gclk_d1 <= 1'b0;
    end else begin
      r_gclk_d0 <= i_gclk;
      r_gclk_d1 <= r_gclk_d0;
    end
  end

  assign o_tick = r_gclk_d0 & ~r_gclk_d1;
endmodule

// File: rtl/sva_seq_checker.sv
// Runtime checker for ev[0] ##1 ev[1] ##1 ... ##1 ev[DEPTH-1] on gclk ticks.
// Optional macro SVA_SEQ_LOG_EN adds a file_fd input and a per-evaluation trace line.
module sva_seq_checker
  import sva_seq_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int TS_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int IMPLY_MODE = 0
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 grst,
`ifdef SVA_SEQ_LOG_EN
  input  int                   file_fd,
`endif
  sva_seq_checker_if.slave     bus
);
  localparam int FS_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                               w_tick;
  ctrl_fsm_t                          r_state;
  logic [DEPTH-1:0]                   r_ev_smp;
  logic [DEPTH-1:0]                   r_act;
  logic [DEPTH-1:0][TS_WIDTH-1:0]     r_ts;
  logic [TS_WIDTH-1:0]                r_tick;
  logic                               r_succ;
  logic [TS_WIDTH-1:0]                r_succ_ts;
  logic                               r_fail;
  logic [FS_W-1:0]                    r_fail_stage;
  logic [TS_WIDTH-1:0]                r_fail_ts;
  logic                               r_fail_multi;
  logic [CNT_WIDTH-1:0]               r_succ_cnt;
  logic [CNT_WIDTH-1:0]               r_fail_cnt;

  logic [MAX_DEPTH-1:0]               w_act_in;
  ts_vec_t                            w_ts_in;
  logic [MAX_DEPTH-1:0]               w_s;
  eval_t                              w_res;
  logic [CNT_WIDTH:0]                 w_succ_sum;
  logic [CNT_WIDTH+4:0]               w_fail_sum;
  logic [CNT_WIDTH-1:0]               w_succ_cnt_nxt;
  logic [CNT_WIDTH-1:0]               w_fail_cnt_nxt;

  sva_gclk_edge u_edge (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_grst    (grst),
    .i_gclk    (bus.gclk),
    .o_tick    (w_tick)
  );

  // Widen stage state to the package's fixed sizes; stage 0 never holds an attempt.
  always_comb begin
    w_act_in = '0;
    w_ts_in  = '0;
    w_s      = '0;
    for (int k = 1; k < DEPTH; k++) begin
      w_act_in[k] = r_act[k];
      w_ts_in[k]  = ts_t'(r_ts[k]);
    end
    w_s[DEPTH-1:0] = r_ev_smp;
    w_res = seq_eval(DEPTH, (IMPLY_MODE != 0), w_act_in, w_ts_in, w_s, ts_t'(r_tick));
  end

  always_comb begin
    w_succ_sum     = {1'b0, r_succ_cnt} + {{CNT_WIDTH{1'b0}}, w_res.succ};
    w_fail_sum     = {5'b0, r_fail_cnt} + {{CNT_WIDTH{1'b0}}, w_res.nfail};
    w_succ_cnt_nxt = w_succ_sum[CNT_WIDTH] ? '1 : w_succ_sum[CNT_WIDTH-1:0];
    w_fail_cnt_nxt = (|w_fail_sum[CNT_WIDTH+4:CNT_WIDTH]) ? '1 : w_fail_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_ev_smp     <= '0;
      r_act        <= '0;
      r_ts         <= '0;
      r_tick       <= '0;
      r_succ       <= 1'b0;
      r_succ_ts    <= '0;
      r_fail       <= 1'b0;
      r_fail_stage <= '0;
      r_fail_ts    <= '0;
      r_fail_multi <= 1'b0;
      r_succ_cnt   <= '0;
      r_fail_cnt   <= '0;
    end else if (grst) begin
      // User reset keeps the lifetime counters.
      r_state      <= IDLE;
      r_ev_smp     <= '0;
      r_act        <= '0;
      r_ts         <= '0;
      r_tick       <= '0;
      r_succ       <= 1'b0;
      r_succ_ts    <= '0;
      r_fail       <= 1'b0;
      r_fail_stage <= '0;
      r_fail_ts    <= '0;
      r_fail_multi <= 1'b0;
    end else begin
      r_succ <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_ev_smp <= bus.ev;
            r_state  <= EVAL;
          end
        end
        EVAL: begin
          r_state <= IDLE;
          r_tick  <= r_tick + TS_WIDTH'(1);
          r_act   <= w_res.act[DEPTH-1:0];
          for (int k = 0; k < DEPTH; k++) begin
            r_ts[k] <= w_res.ts[k][TS_WIDTH-1:0];
          end
          r_succ     <= w_res.succ;
          r_fail     <= (w_res.nfail != 5'd0);
          r_succ_cnt <= w_succ_cnt_nxt;
          r_fail_cnt <= w_fail_cnt_nxt;
          if (w_res.succ) begin
            r_succ_ts <= w_res.succ_ts[TS_WIDTH-1:0];
          end
          if (w_res.nfail != 5'd0) begin
            r_fail_stage <= w_res.fail_stage[FS_W-1:0];
            r_fail_ts    <= w_res.fail_ts[TS_WIDTH-1:0];
            r_fail_multi <= (w_res.nfail > 5'd1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SVA_SEQ_LOG_EN
  always @(posedge sys_clk) begin
    if (sys_rst_n && !grst && r_state == EVAL) begin
      $display("act=%b ev=%b%s%s @%0t", r_act, r_ev_smp,
               w_res.succ ? $sformatf(" finish ts=%0d", w_res.succ_ts[TS_WIDTH-1:0]) : "",
               (w_res.nfail != 5'd0) ? $sformatf(" error stage=%0d ts=%0d", w_res.fail_stage,
                                                 w_res.fail_ts[TS_WIDTH-1:0]) : "",
               $time);
    end
  end
`endif

  assign bus.busy       = |r_act;
  assign bus.succ       = r_succ;
  assign bus.succ_ts    = r_succ_ts;
  assign bus.fail       = r_fail;
  assign bus.fail_stage = r_fail_stage;
  assign bus.fail_ts    = r_fail_ts;
  assign bus.fail_multi = r_fail_multi;
  assign bus.succ_cnt   = r_succ_cnt;
  assign bus.fail_cnt   = r_fail_cnt;
endmodule

// File: tb/tb_sva_seq_checker.sv
// Directed bench: two checker instances (DEPTH=2 strict with 2-bit counters,
// DEPTH=3 implication mode) driven tick by tick from a table of expected reports.
module tb_sva_seq_checker;

  typedef struct {
    int succ;
    int succTs;
    int fail;
    int failStage;
    int failTs;
    int failMulti;
    int succCnt;
    int failCnt;
    int busy;
  } exp_t;

  typedef struct {
    logic [1:0] ev2;
    logic [2:0] ev3;
    exp_t       e2;
    exp_t       e3;
  } vec_t;

  logic       sysClk  = 1'b0;
  logic       sysRstN = 1'b0;
  logic       gRst    = 1'b0;
  logic       gClk    = 1'b0;
  logic [1:0] ev2     = '0;
  logic [2:0] ev3     = '0;
  int         vecCount  = 0;
  int         missCount = 0;
  vec_t       vecs[15];
  exp_t       zeroExp;

  always #5 sysClk = ~sysClk;

  sva_seq_checker_if #(.DEPTH(2), .TS_WIDTH(8), .CNT_WIDTH(2))  bus2 ();
  sva_seq_checker_if #(.DEPTH(3), .TS_WIDTH(8), .CNT_WIDTH(16)) bus3 ();

  assign bus2.gclk = gClk;
  assign bus2.ev   = ev2;
  assign bus3.gclk = gClk;
  assign bus3.ev   = ev3;

  sva_seq_checker #(.DEPTH(2), .TS_WIDTH(8), .CNT_WIDTH(2), .IMPLY_MODE(0)) dut2 (
    .sys_clk   (sysClk),
    .sys_rst_n (sysRstN),
    .grst      (gRst),
`ifdef SVA_SEQ_LOG_EN
    .file_fd   (1),
`endif
    .bus       (bus2)
  );

  sva_seq_checker #(.DEPTH(3), .TS_WIDTH(8), .CNT_WIDTH(16), .IMPLY_MODE(1)) dut3 (
    .sys_clk   (sysClk),
    .sys_rst_n (sysRstN),
    .grst      (gRst),
`ifdef SVA_SEQ_LOG_EN
    .file_fd   (1),
`endif
    .bus       (bus3)
  );

  function automatic exp_t grab2();
    return '{int'(bus2.succ), int'(bus2.succ_ts), int'(bus2.fail), int'(bus2.fail_stage),
             int'(bus2.fail_ts), int'(bus2.fail_multi), int'(bus2.succ_cnt),
             int'(bus2.fail_cnt), int'(bus2.busy)};
  endfunction

  function automatic exp_t grab3();
    return '{int'(bus3.succ), int'(bus3.succ_ts), int'(bus3.fail), int'(bus3.fail_stage),
             int'(bus3.fail_ts), int'(bus3.fail_multi), int'(bus3.succ_cnt),
             int'(bus3.fail_cnt), int'(bus3.busy)};
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkExp(input string tag, input exp_t a, input exp_t e);
    checkOutput({tag, ".succ"},       a.succ,      e.succ);
    checkOutput({tag, ".succ_ts"},    a.succTs,    e.succTs);
    checkOutput({tag, ".fail"},       a.fail,      e.fail);
    checkOutput({tag, ".fail_stage"}, a.failStage, e.failStage);
    checkOutput({tag, ".fail_ts"},    a.failTs,    e.failTs);
    checkOutput({tag, ".fail_multi"}, a.failMulti, e.failMulti);
    checkOutput({tag, ".succ_cnt"},   a.succCnt,   e.succCnt);
    checkOutput({tag, ".fail_cnt"},   a.failCnt,   e.failCnt);
    checkOutput({tag, ".busy"},       a.busy,      e.busy);
  endtask

  // One gclk period (3 high, 3 low); reports are sampled on the negedge two cycles after the tick cycle.
  task automatic applyStimulus(input logic [1:0] e2, input logic [2:0] e3,
                               output exp_t a2, output exp_t a3);
    ev2  = e2;
    ev3  = e3;
    gClk = 1'b1;
    repeat (3) @(negedge sysClk);
    a2   = grab2();
    a3   = grab3();
    gClk = 1'b0;
    repeat (3) @(negedge sysClk);
  endtask

  task automatic runRow(input int idx);
    exp_t a2, a3;
    applyStimulus(vecs[idx].ev2, vecs[idx].ev3, a2, a3);
    checkExp($sformatf("row%0d.d2", idx), a2, vecs[idx].e2);
    checkExp($sformatf("row%0d.d3", idx), a3, vecs[idx].e3);
  endtask

  initial begin
    exp_t a2, a3;
    zeroExp = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    // fields: succ, succTs, fail, failStage, failTs, failMulti, succCnt, failCnt, busy
    vecs[0]  = '{2'b01, 3'b001, '{0,0,0,0,0,0,0,0,1},  '{0,0,0,0,0,0,0,0,1}};
    vecs[1]  = '{2'b10, 3'b011, '{1,0,1,0,1,0,1,1,0},  '{0,0,0,0,0,0,0,0,1}};
    vecs[2]  = '{2'b00, 3'b000, '{0,0,1,0,2,0,1,2,0},  '{0,0,1,2,0,1,0,2,0}};
    vecs[3]  = '{2'b00, 3'b000, '{0,0,1,0,3,0,1,3,0},  '{0,0,0,2,0,1,0,2,0}};
    vecs[4]  = '{2'b00, 3'b000, '{0,0,1,0,4,0,1,3,0},  '{0,0,0,2,0,1,0,2,0}};
    vecs[5]  = '{2'b00, 3'b000, '{0,0,1,0,5,0,1,3,0},  '{0,0,0,2,0,1,0,2,0}};
    vecs[6]  = '{2'b11, 3'b111, '{0,0,0,0,5,0,1,3,1},  '{0,0,0,2,0,1,0,2,1}};
    vecs[7]  = '{2'b11, 3'b111, '{1,6,0,0,5,0,2,3,1},  '{0,0,0,2,0,1,0,2,1}};
    vecs[8]  = '{2'b11, 3'b111, '{1,7,0,0,5,0,3,3,1},  '{1,6,0,2,0,1,1,2,1}};
    vecs[9]  = '{2'b11, 3'b111, '{1,8,0,0,5,0,3,3,1},  '{1,7,0,2,0,1,2,2,1}};
    vecs[10] = '{2'b00, 3'b000, '{0,8,1,1,9,1,3,3,0},  '{0,7,1,2,8,1,2,4,0}};
    vecs[11] = '{2'b00, 3'b000, '{0,8,1,0,11,0,3,3,0}, '{0,7,0,2,8,1,2,4,0}};
    // after grst: tick count restarts at 0, counters retained
    vecs[12] = '{2'b00, 3'b000, '{0,0,1,0,0,0,3,3,0},  '{0,0,0,0,0,0,2,4,0}};
    vecs[13] = '{2'b01, 3'b001, '{0,0,0,0,0,0,3,3,1},  '{0,0,0,0,0,0,2,4,1}};
    vecs[14] = '{2'b10, 3'b000, '{1,1,1,0,2,0,3,3,0},  '{0,0,1,1,1,0,2,5,0}};

    $display("[TB] reset state");
    repeat (3) @(negedge sysClk);
    checkExp("rst.d2", grab2(), zeroExp);
    checkExp("rst.d3", grab3(), zeroExp);
    sysRstN = 1'b1;
    repeat (2) @(negedge sysClk);
    checkExp("post_rst.d2", grab2(), zeroExp);

    $display("[TB] table vectors 0..11");
    for (int i = 0; i < 12; i++) runRow(i);

    $display("[TB] implication idle run");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'b00, 3'b000, a2, a3);
      checkOutput($sformatf("idle%0d.d3.fail", i),     a3.fail,    0);
      checkOutput($sformatf("idle%0d.d3.fail_cnt", i), a3.failCnt, 4);
      checkOutput($sformatf("idle%0d.d3.busy", i),     a3.busy,    0);
      checkOutput($sformatf("idle%0d.d2.fail_ts", i),  a2.failTs,  12 + i);
    end

    $display("[TB] grst with attempts in flight");
    applyStimulus(2'b01, 3'b001, a2, a3);
    checkOutput("pre_grst.d2.busy", a2.busy, 1);
    checkOutput("pre_grst.d3.busy", a3.busy, 1);
    gRst = 1'b1;
    @(negedge sysClk);
    gRst = 1'b0;
    checkExp("grst.d2", grab2(), '{0,0,0,0,0,0,3,3,0});
    checkExp("grst.d3", grab3(), '{0,0,0,0,0,0,2,4,0});
    @(negedge sysClk);
    for (int i = 12; i < 15; i++) runRow(i);

    $display("[TB] async reset during EVAL");
    ev2  = 2'b00;
    ev3  = 3'b000;
    gClk = 1'b1;
    @(posedge sysClk);
    @(posedge sysClk);
    #2 sysRstN = 1'b0;
    #1;
    checkExp("arst.d2", grab2(), zeroExp);
    checkExp("arst.d3", grab3(), zeroExp);
    @(negedge sysClk);
    gClk = 1'b0;
    repeat (2) @(negedge sysClk);
    sysRstN = 1'b1;
    repeat (2) @(negedge sysClk);
    checkOutput("arst_rel.d2.fail_cnt", int'(bus2.fail_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
